// File: rtl/frame_scanout.sv
// frame_scanout: display-side reader for a palette-index frame buffer.
//
// Walks the VGA raster, issues one registered read_address per pixel to a
// synchronous-read RAM (1-clock latency) and re-aligns the returned palette
// index with sync/blank/DrawX/DrawY so that every output describes one pixel.
//
// Ports
//   Clk          system clock
//   Reset        synchronous, active-low reset
//   pix_ce       pixel-clock enable; the raster advances one pixel per Clk
//                edge with pix_ce=1
//   read_address registered RAM read address
//   data_In      RAM read data (valid one Clk after read_address is sampled)
//   pixel_index  palette index of the output pixel, 0 while blanked
//   DrawX/DrawY  coordinates of the output pixel
//   hs/vs        active-low syncs of the output pixel
//   blank_n      1 for a visible output pixel
//   frame_start  one-Clk pulse with output pixel (0,0)
//
// Timing contract: pix_ce is a plain enable with no back-pressure. A pixel is
// issued on the edge where pix_ce=1 and its outputs load exactly two Clk
// edges later, whatever the spacing of later pix_ce edges.
module frame_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int PIX_W    = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_ce,
  output logic [ADDR_W-1:0] read_address,
  input  logic [PIX_W-1:0]  data_In,
  output logic [PIX_W-1:0]  pixel_index,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic              hs,
  output logic              vs,
  output logic              blank_n,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Stage 0: raster position and read address (advance only on pix_ce)
  logic [9:0]        h_q, h_d, v_q, v_d;
  logic [9:0]        h_nxt, v_nxt;
  logic              active_nxt;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0] read_address_q, read_address_d;

  // Sideband delay line, clocked every Clk
  logic              ce_q;
  logic              d1_valid_q, d1_active_q, d1_hs_q, d1_vs_q, d1_fs_q;
  logic [9:0]        d1_h_q, d1_v_q;
  logic              s0_active, s0_hs, s0_vs, s0_fs;

  // Output registers
  logic [PIX_W-1:0]  pixel_index_q, pixel_index_d;
  logic [9:0]        drawx_q, drawx_d, drawy_q, drawy_d;
  logic              hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic              frame_start_q, frame_start_d;

  always_comb begin
    h_nxt = h_q + 10'd1;
    v_nxt = v_q;
    if (h_q == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    active_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);

    h_d            = h_q;
    v_d            = v_q;
    addr_cnt_d     = addr_cnt_q;
    read_address_d = read_address_q;
    if (pix_ce) begin
      h_d = h_nxt;
      v_d = v_nxt;
      if (active_nxt) begin
        // The counter holds the address of the next active pixel; it is
        // re-anchored at (0,0) so the frame always starts at address 0.
        if ((h_nxt == '0) && (v_nxt == '0)) begin
          read_address_d = '0;
          addr_cnt_d     = ADDR_W'(1);
        end else begin
          read_address_d = addr_cnt_q;
          addr_cnt_d     = addr_cnt_q + ADDR_W'(1);
        end
      end
    end
  end

  // Attributes of the pixel currently held in stage 0
  always_comb begin
    s0_active = (h_q < H_ACT) && (v_q < V_ACT);
    s0_hs     = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    s0_vs     = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    s0_fs     = (h_q == '0) && (v_q == '0);
  end

  // ce_q marks the Clk after an issue edge; d1 is captured one Clk later,
  // when data_In for that pixel becomes valid at the next edge.
  always_comb begin
    pixel_index_d = pixel_index_q;
    drawx_d       = drawx_q;
    drawy_d       = drawy_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    frame_start_d = 1'b0;
    if (d1_valid_q) begin
      pixel_index_d = d1_active_q ? data_In : '0;
      drawx_d       = d1_h_q;
      drawy_d       = d1_v_q;
      hs_d          = d1_hs_q;
      vs_d          = d1_vs_q;
      blank_n_d     = d1_active_q;
      frame_start_d = d1_fs_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      h_q            <= H_LAST;
      v_q            <= V_LAST;
      addr_cnt_q     <= '0;
      read_address_q <= '0;
      ce_q           <= 1'b0;
      d1_valid_q     <= 1'b0;
      d1_active_q    <= 1'b0;
      d1_hs_q        <= 1'b1;
      d1_vs_q        <= 1'b1;
      d1_fs_q        <= 1'b0;
      d1_h_q         <= '0;
      d1_v_q         <= '0;
      pixel_index_q  <= '0;
      drawx_q        <= '0;
      drawy_q        <= '0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      blank_n_q      <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      h_q            <= h_d;
      v_q            <= v_d;
      addr_cnt_q     <= addr_cnt_d;
      read_address_q <= read_address_d;
      ce_q           <= pix_ce;
      d1_valid_q     <= ce_q;
      d1_active_q    <= s0_active;
      d1_hs_q        <= s0_hs;
      d1_vs_q        <= s0_vs;
      d1_fs_q        <= s0_fs;
      d1_h_q         <= h_q;
      d1_v_q         <= v_q;
      pixel_index_q  <= pixel_index_d;
      drawx_q        <= drawx_d;
      drawy_q        <= drawy_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      blank_n_q      <= blank_n_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign read_address = read_address_q;
  assign pixel_index  = pixel_index_q;
  assign DrawX        = drawx_q;
  assign DrawY        = drawy_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign blank_n      = blank_n_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: bench for frame_scanout.
// Two instances share Reset/pix_ce: dut0 at the default 640x480 raster and
// dut1 on a tiny raster (16x10 total, 8x4 visible) so whole frames fit.
// Each has a RAM model returning mem[a] = a[7:0] with 1-clock latency.
// A reference model derives every expected value from the raster position
// (pixel count since reset modulo frame size) and a queue of pending outputs.
module tb_frame_scanout;

  localparam int NI = 2;
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 4, S_VF = 2, S_VS = 2, S_VB = 2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset  = 1'b0;
  logic pix_ce = 1'b0;

  logic [18:0] addr0, addr1;
  logic [7:0]  din0, din1, pix0, pix1;
  logic [9:0]  x0, y0, x1, y1;
  logic        hs0, vs0, bn0, fs0, hs1, vs1, bn1, fs1;

  frame_scanout dut0 (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .read_address(addr0),
    .data_In(din0), .pixel_index(pix0), .DrawX(x0), .DrawY(y0),
    .hs(hs0), .vs(vs0), .blank_n(bn0), .frame_start(fs0)
  );

  frame_scanout #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .ADDR_W(19), .PIX_W(8)
  ) dut1 (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .read_address(addr1),
    .data_In(din1), .pixel_index(pix1), .DrawX(x1), .DrawY(y1),
    .hs(hs1), .vs(vs1), .blank_n(bn1), .frame_start(fs1)
  );

  // RAM models: synchronous read, contents equal low address byte
  always @(posedge Clk) begin
    din0 <= addr0[7:0];
    din1 <= addr1[7:0];
  end

  // ---------------- reference model ----------------
  int ha  [NI] = '{640, S_HA};
  int hf  [NI] = '{16,  S_HF};
  int hsy [NI] = '{96,  S_HS};
  int hb  [NI] = '{48,  S_HB};
  int va  [NI] = '{480, S_VA};
  int vf  [NI] = '{10,  S_VF};
  int vsy [NI] = '{2,   S_VS};
  int vb  [NI] = '{33,  S_VB};

  // packed output: {pixel_index, DrawX, DrawY, hs, vs, blank_n, frame_start}
  localparam logic [31:0] RST_EXP = {8'h00, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  int          pos      [NI];
  int          exp_addr [NI];
  logic [31:0] cur_exp  [NI];
  logic [31:0] exp_q0[$], exp_q1[$];
  int          due_q0[$], due_q1[$];
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  // frame_start spacing tracking for dut1, in pix_ce counts at issue time
  int c0 = 0, c1 = 0, c2 = 0, last_fs = -1;
  int fs_dut1 = 0, fs_mod1 = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic ce, input logic rst_n);
    int h, v, ht, vt, dummy;
    logic act, hs_e, vs_e;
    logic [31:0] av, e;
    logic [7:0] pe;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        pos[i]      = -1;
        exp_addr[i] = 0;
        cur_exp[i]  = RST_EXP;
      end else begin
        cur_exp[i][0] = 1'b0;
        if (i == 0) begin
          if (due_q0.size() > 0 && due_q0[0] == cyc) begin
            cur_exp[0] = exp_q0.pop_front();
            dummy = due_q0.pop_front();
          end
        end else begin
          if (due_q1.size() > 0 && due_q1[0] == cyc) begin
            cur_exp[1] = exp_q1.pop_front();
            dummy = due_q1.pop_front();
          end
        end
        if (ce) begin
          ht = ha[i] + hf[i] + hsy[i] + hb[i];
          vt = va[i] + vf[i] + vsy[i] + vb[i];
          pos[i] = (pos[i] + 1) % (ht * vt);
          h = pos[i] % ht;
          v = pos[i] / ht;
          act  = (h < ha[i]) && (v < va[i]);
          hs_e = !((h >= ha[i] + hf[i]) && (h < ha[i] + hf[i] + hsy[i]));
          vs_e = !((v >= va[i] + vf[i]) && (v < va[i] + vf[i] + vsy[i]));
          av = 32'(v * ha[i] + h);
          if (act) exp_addr[i] = int'(av);
          pe = act ? av[7:0] : 8'h00;
          e  = {pe, 10'(h), 10'(v), hs_e, vs_e, act, (pos[i] == 0)};
          if (i == 0) begin
            exp_q0.push_back(e);
            due_q0.push_back(cyc + 2);
          end else begin
            exp_q1.push_back(e);
            due_q1.push_back(cyc + 2);
          end
        end
      end
    end
    if (!rst_n) begin
      exp_q0.delete(); due_q0.delete();
      exp_q1.delete(); due_q1.delete();
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic ce, input logic rst_n);
    @(negedge Clk);
    pix_ce = ce;
    Reset  = rst_n;
    @(posedge Clk);
    cyc++;
    model_edge(ce, rst_n);
    #1;
    check("addr0", 64'(addr0), 64'(exp_addr[0]));
    check("out0",  64'({pix0, x0, y0, hs0, vs0, bn0, fs0}), 64'(cur_exp[0]));
    check("addr1", 64'(addr1), 64'(exp_addr[1]));
    check("out1",  64'({pix1, x1, y1, hs1, vs1, bn1, fs1}), 64'(cur_exp[1]));
    if (!rst_n) begin
      c0 = 0; c1 = 0; c2 = 0; last_fs = -1;
    end else begin
      c2 = c1;
      c1 = c0;
      c0 = c0 + (ce ? 1 : 0);
      if (fs1) begin
        if (last_fs >= 0) check("fs_gap1", 64'(c2 - last_fs), 64'(160));
        last_fs = c2;
      end
    end
    if (fs1) fs_dut1++;
    if (cur_exp[1][0]) fs_mod1++;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst_n;
    logic        ce;
    logic [18:0] addr;
    logic [7:0]  pix;
    logic [9:0]  x;
    logic        blank_n;
    logic        fs;
  } vec_t;

  vec_t vecs [8];

  int guard;
  int hs_cnt, hs_first, bad_blank;
  logic [7:0]  p639, p0_1;
  logic [18:0] a700, a_issue;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 19'd0, 8'h00, 10'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 19'd0, 8'h00, 10'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 19'd0, 8'h00, 10'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 19'd0, 8'h00, 10'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 19'd1, 8'h00, 10'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 19'd2, 8'h00, 10'd0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 19'd3, 8'h01, 10'd1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 19'd4, 8'h02, 10'd2, 1'b1, 1'b0};

    model_edge(1'b0, 1'b0);

    // reset for 3 clk then run
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].ce, vecs[i].rst_n);
      check($sformatf("vec%0d", i),
            64'({addr0, pix0, x0, bn0, fs0}),
            64'({vecs[i].addr, vecs[i].pix, vecs[i].x, vecs[i].blank_n, vecs[i].fs}));
    end

    // line 0 into line 1 with pix_ce every clk
    hs_cnt = 0; hs_first = -1; bad_blank = 0;
    p639 = 8'h00; p0_1 = 8'h00; a700 = 19'd0; a_issue = 19'd0;
    guard = 0;
    while (pos[0] != 805 && guard < 2000) begin
      tick(1'b1, 1'b1);
      guard++;
      if (y0 == 10'd0 && !hs0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(x0);
      end
      if (!bn0 && pix0 != 8'h00) bad_blank++;
      if (x0 == 10'd639 && y0 == 10'd0) p639 = pix0;
      if (x0 == 10'd700 && y0 == 10'd0) a700 = addr0;
      if (x0 == 10'd0 && y0 == 10'd1) p0_1 = pix0;
      if (pos[0] == 800) a_issue = addr0;
    end
    check("line0_bound", 64'(guard < 2000), 64'(1));
    check("hs_low_count", 64'(hs_cnt), 64'(96));
    check("hs_first_x", 64'(hs_first), 64'(656));
    check("blank_pix_zero", 64'(bad_blank), 64'(0));
    check("pix_639_0", 64'(p639), 64'(8'h7F));
    check("addr_held_639", 64'(a700), 64'(639));
    check("addr_0_1", 64'(a_issue), 64'(640));
    check("pix_0_1", 64'(p0_1), 64'(8'h80));

    // pix_ce every other clk
    for (int i = 0; i < 400; i++) tick((i % 2) == 0, 1'b1);

    // reset for one clk at (300,1)
    guard = 0;
    while (pos[0] != 1100 && guard < 3000) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    check("reach_300_1", 64'(guard < 3000), 64'(1));
    tick(1'b1, 1'b0);
    check("midreset_outs",
          64'({addr0, pix0, x0, y0, hs0, vs0, bn0, fs0}),
          64'({19'd0, 8'h00, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    tick(1'b1, 1'b1);
    check("restart_addr", 64'(addr0), 64'(0));
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("restart_origin", 64'({fs0, bn0, x0, y0}), 64'({1'b1, 1'b1, 10'd0, 10'd0}));

    // random pix_ce
    for (int i = 0; i < 1500; i++) tick(1'($urandom_range(0, 1)), 1'b1);

    // pix_ce low for 50 clk mid-line, then resume
    guard = 0;
    while ((pos[0] % 800) != 100 && guard < 1000) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    check("reach_midline", 64'(guard < 1000), 64'(1));
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) tick(1'b1, 1'b1);

    check("fs_count1", 64'(fs_dut1), 64'(fs_mod1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
